// File: rtl/sw_job_ctrl.sv
// sw_job_ctrl: MMIO register file and job sequencer for the Smith-Waterman core
module sw_job_ctrl #(
    parameter int TIMEOUT_W = 32,
    parameter int SCORE_W   = 16
) (
    input  logic               ha_pclock,
    input  logic               reset,
    input  logic               req_val,
    input  logic               req_rnw,
    input  logic [0:23]        req_ad,
    input  logic [0:63]        req_wdata,
    output logic               rsp_ack,
    output logic [0:63]        rsp_rdata,
    output logic               core_start,
    output logic               core_abort,
    input  logic               core_done,
    input  logic [SCORE_W-1:0] core_score,
    output logic [0:63]        query_ea,
    output logic [0:63]        db_ea,
    output logic [0:31]        query_len,
    output logic [0:31]        db_len,
    output logic               irq
);
    typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, RUN = 3'd2, DONE = 3'd3, ERROR = 3'd4} state_t;
    state_t state, state_nx;
    logic [TIMEOUT_W-1:0] wd;
    logic [SCORE_W-1:0] result;
    logic [31:0] job_count;
    logic [0:63] scratch, rd_mux;
    logic [2:0] idx, idx1;
    logic err_sticky, v1, rnw1, wr, ctrl_wr, busy, abort_ok, start_req, start_ok, clear_ok, desc_wr, wd_exp, run_done;
    logic unused_ad;
    assign unused_ad = ^{req_ad[0:19], req_ad[23]};
    assign idx       = req_ad[20:22];
    assign wr        = req_val & ~req_rnw;
    assign ctrl_wr   = wr && idx == 3'd0;
    assign busy      = state == START || state == RUN;
    // abort outranks start, which outranks clear, within one CTRL write
    assign abort_ok  = ctrl_wr & req_wdata[1] & busy;
    assign start_req = ctrl_wr & req_wdata[0] & ~abort_ok;
    assign start_ok  = start_req & (state == IDLE || state == DONE);
    assign clear_ok  = ctrl_wr & req_wdata[2] & ~abort_ok & ~start_req;
    assign desc_wr   = wr && idx inside {3'd1, 3'd2, 3'd3};
    // expiry fires on the cycle the counter steps onto all-ones
    assign wd_exp    = wd == {{(TIMEOUT_W-1){1'b1}}, 1'b0};
    assign run_done  = state == RUN && core_done && !abort_ok;
    assign core_start = state == START;
    assign core_abort = state == ERROR;
    assign irq        = state == DONE || state == ERROR;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start_ok ? START : IDLE;
            START:   state_nx = abort_ok ? ERROR : RUN;
            RUN:     state_nx = abort_ok ? ERROR : core_done ? DONE : wd_exp ? ERROR : RUN;
            DONE:    state_nx = start_ok ? START : clear_ok ? IDLE : DONE;
            ERROR:   state_nx = clear_ok ? IDLE : ERROR;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge ha_pclock) begin
        state <= reset ? IDLE : state_nx;
    end
    always_comb begin
        rd_mux = idx1 == 3'd0 ? {state, err_sticky, 28'b0, job_count} :
                 idx1 == 3'd1 ? query_ea :
                 idx1 == 3'd2 ? db_ea :
                 idx1 == 3'd3 ? {query_len, db_len} :
                 idx1 == 3'd4 ? 64'(result) :
                 idx1 == 3'd5 ? scratch : 64'd0;
    end
    always_ff @(posedge ha_pclock) begin
        if (reset) begin
            query_ea   <= '0;
            db_ea      <= '0;
            query_len  <= '0;
            db_len     <= '0;
            scratch    <= '0;
            err_sticky <= 1'b0;
            wd         <= '0;
            result     <= '0;
            job_count  <= '0;
            v1         <= 1'b0;
            rnw1       <= 1'b0;
            idx1       <= '0;
            rsp_ack    <= 1'b0;
            rsp_rdata  <= '0;
        end else begin
            if (wr && !busy && idx == 3'd1) query_ea <= req_wdata;
            if (wr && !busy && idx == 3'd2) db_ea <= req_wdata;
            if (wr && !busy && idx == 3'd3) {query_len, db_len} <= req_wdata;
            if (wr && idx == 3'd5) scratch <= req_wdata;
            if ((desc_wr && busy) || (start_req && !start_ok)) err_sticky <= 1'b1;
            else if (clear_ok) err_sticky <= 1'b0;
            wd <= state == RUN ? wd + TIMEOUT_W'(1) : '0;
            if (start_ok) result <= '0;
            else if (run_done) result <= core_score;
            if (run_done) job_count <= job_count + 32'd1;
            v1        <= req_val;
            rnw1      <= req_rnw;
            idx1      <= idx;
            rsp_ack   <= v1;
            rsp_rdata <= v1 && rnw1 ? rd_mux : 64'd0;
        end
    end
endmodule

// File: tb/tb_sw_job_ctrl.sv
// tb_sw_job_ctrl: table-driven and scoreboarded checks of the sw_job_ctrl register file and job FSM
module tb_sw_job_ctrl;
    localparam int TW = 4;
    localparam int SW = 16;
    localparam logic [63:0] C_START = 64'h8000_0000_0000_0000;
    localparam logic [63:0] C_ABORT = 64'h4000_0000_0000_0000;
    localparam logic [63:0] C_CLEAR = 64'h2000_0000_0000_0000;
    logic ha_pclock = 1'b0, reset = 1'b1, req_val = 1'b0, req_rnw = 1'b0, core_done = 1'b0;
    logic [0:23] req_ad = '0;
    logic [0:63] req_wdata = '0;
    logic [SW-1:0] core_score = '0;
    logic rsp_ack, core_start, core_abort, irq;
    logic [0:63] rsp_rdata, query_ea, db_ea;
    logic [0:31] query_len, db_len;
    sw_job_ctrl #(.TIMEOUT_W(TW), .SCORE_W(SW)) dut (
        .ha_pclock(ha_pclock), .reset(reset), .req_val(req_val), .req_rnw(req_rnw),
        .req_ad(req_ad), .req_wdata(req_wdata), .rsp_ack(rsp_ack), .rsp_rdata(rsp_rdata),
        .core_start(core_start), .core_abort(core_abort), .core_done(core_done),
        .core_score(core_score), .query_ea(query_ea), .db_ea(db_ea),
        .query_len(query_len), .db_len(db_len), .irq(irq)
    );
    always #5 ha_pclock = ~ha_pclock;
    int cyc = 0;
    always @(posedge ha_pclock) cyc <= cyc + 1;
    typedef struct {logic [63:0] exp; int due; logic [2:0] idx;} sb_t;
    typedef struct {bit rnw; logic [2:0] idx; logic [63:0] wd; logic [63:0] exp;} vec_t;
    sb_t sb[$];
    vec_t t1[13];
    logic [63:0] exp8[8];
    int checks = 0, errors = 0, starts = 0, s0;
    function automatic logic [63:0] st(int s, bit e, int j);
        return {s[2:0], e, 28'b0, j[31:0]};
    endfunction
    task automatic chk(string n, logic [63:0] a, logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask
    task automatic req(bit rnw, logic [2:0] idx, logic [63:0] wd, logic [63:0] exp);
        sb_t s;
        @(negedge ha_pclock);
        req_val = 1'b1;
        req_rnw = rnw;
        req_ad = {20'b0, idx, 1'b0};
        req_wdata = wd;
        s.exp = rnw ? exp : 64'd0;
        s.due = cyc + 2;
        s.idx = idx;
        sb.push_back(s);
    endtask
    task automatic nop(int n);
        repeat (n) begin
            @(negedge ha_pclock);
            req_val = 1'b0;
            req_wdata = '0;
            core_done = 1'b0;
        end
    endtask
    initial begin
        #50000;
        $display("FAIL global timeout: simulation did not finish");
        $fatal(1);
    end
    initial begin
        sb_t e;
        fork
            forever begin
                @(negedge ha_pclock);
                if (core_start) starts++;
                if (rsp_ack) begin
                    if (sb.size() == 0) chk("ack without request", 64'(rsp_ack), 0);
                    else begin
                        e = sb.pop_front();
                        chk($sformatf("ack cycle idx%0d", e.idx), 64'(cyc), 64'(e.due));
                        chk($sformatf("rdata idx%0d", e.idx), rsp_rdata, e.exp);
                    end
                end else if (sb.size() > 0 && sb[0].due <= cyc) begin
                    chk("missing ack", 64'(rsp_ack), 1);
                    void'(sb.pop_front());
                end
            end
        join_none
        t1 = '{
            '{1'b0, 3'd1, 64'h1000, 64'd0},
            '{1'b0, 3'd2, 64'h2000, 64'd0},
            '{1'b0, 3'd3, 64'h0000_0040_0000_0080, 64'd0},
            '{1'b0, 3'd5, 64'hDEAD_BEEF_CAFE_F00D, 64'd0},
            '{1'b0, 3'd6, 64'h1234, 64'd0},
            '{1'b1, 3'd1, 64'd0, 64'h1000},
            '{1'b1, 3'd2, 64'd0, 64'h2000},
            '{1'b1, 3'd3, 64'd0, 64'h0000_0040_0000_0080},
            '{1'b1, 3'd4, 64'd0, 64'd0},
            '{1'b1, 3'd5, 64'd0, 64'hDEAD_BEEF_CAFE_F00D},
            '{1'b1, 3'd6, 64'd0, 64'd0},
            '{1'b1, 3'd7, 64'd0, 64'd0},
            '{1'b1, 3'd0, 64'd0, 64'd0}
        };
        exp8 = '{64'd0, 64'hABC, 64'd0, 64'd0, 64'd0, 64'h5A5A, 64'd0, 64'd0};
        nop(3);
        reset = 1'b0;
        chk("reset core_start", 64'(core_start), 0);
        chk("reset core_abort", 64'(core_abort), 0);
        chk("reset irq", 64'(irq), 0);
        chk("reset query_ea", query_ea, 0);
        chk("reset lengths", {query_len, db_len}, 0);
        // descriptor and map table, issued back to back
        for (int i = 0; i < 13; i++) req(t1[i].rnw, t1[i].idx, t1[i].wd, t1[i].exp);
        nop(3);
        chk("query_ea port", query_ea, 64'h1000);
        chk("db_ea port", db_ea, 64'h2000);
        chk("query_len port", 64'(query_len), 64'h40);
        chk("db_len port", 64'(db_len), 64'h80);
        // first job
        s0 = starts;
        req(1'b0, 3'd0, C_START, 0);
        nop(1);
        req(1'b1, 3'd0, 0, st(2, 0, 0));
        nop(3);
        core_done = 1'b1;
        core_score = 16'h01F3;
        nop(2);
        chk("job1 irq", 64'(irq), 1);
        chk("job1 start pulses", 64'(starts - s0), 1);
        req(1'b1, 3'd4, 0, 64'h1F3);
        req(1'b1, 3'd0, 0, st(3, 0, 1));
        nop(3);
        // illegal writes during a run
        s0 = starts;
        req(1'b0, 3'd0, C_START, 0);
        req(1'b0, 3'd1, 64'hFFFF, 0);
        req(1'b0, 3'd0, C_START, 0);
        req(1'b1, 3'd1, 0, 64'h1000);
        req(1'b1, 3'd0, 0, st(2, 1, 1));
        req(1'b1, 3'd4, 0, 0);
        nop(3);
        core_done = 1'b1;
        core_score = 16'h0022;
        nop(3);
        chk("job2 start pulses", 64'(starts - s0), 1);
        chk("job2 query_ea kept", query_ea, 64'h1000);
        req(1'b1, 3'd0, 0, st(3, 1, 2));
        req(1'b0, 3'd0, C_CLEAR, 0);
        nop(1);
        req(1'b1, 3'd0, 0, st(0, 0, 2));
        req(1'b1, 3'd4, 0, 64'h22);
        nop(3);
        // abort collides with core_done
        req(1'b0, 3'd0, C_START, 0);
        nop(2);
        req(1'b0, 3'd0, C_ABORT, 0);
        core_done = 1'b1;
        core_score = 16'h0055;
        nop(2);
        chk("abort core_abort", 64'(core_abort), 1);
        chk("abort irq", 64'(irq), 1);
        req(1'b1, 3'd0, 0, st(4, 0, 2));
        req(1'b1, 3'd4, 0, 0);
        nop(2);
        req(1'b0, 3'd0, C_CLEAR, 0);
        nop(1);
        chk("clear drops core_abort", 64'(core_abort), 0);
        chk("clear drops irq", 64'(irq), 0);
        req(1'b1, 3'd0, 0, st(0, 0, 2));
        nop(3);
        // watchdog expiry after 15 RUN cycles
        req(1'b0, 3'd0, C_START, 0);
        nop(16);
        chk("wd still running", 64'(core_abort), 0);
        nop(1);
        chk("wd expired", 64'(core_abort), 1);
        req(1'b0, 3'd0, C_CLEAR, 0);
        nop(2);
        chk("wd cleared", 64'(core_abort), 0);
        // core_done on the expiry cycle wins
        req(1'b0, 3'd0, C_START, 0);
        nop(16);
        core_done = 1'b1;
        core_score = 16'h7777;
        nop(1);
        chk("done at expiry irq", 64'(irq), 1);
        chk("done at expiry no abort", 64'(core_abort), 0);
        nop(1);
        core_done = 1'b1;
        core_score = 16'h1111;
        nop(1);
        req(1'b1, 3'd0, 0, st(3, 0, 3));
        req(1'b1, 3'd4, 0, 64'h7777);
        req(1'b0, 3'd0, C_CLEAR, 0);
        nop(1);
        // reset in the middle of a run
        req(1'b0, 3'd0, C_START, 0);
        nop(4);
        reset = 1'b1;
        nop(1);
        reset = 1'b0;
        chk("rst core_start", 64'(core_start), 0);
        chk("rst core_abort", 64'(core_abort), 0);
        chk("rst irq", 64'(irq), 0);
        chk("rst query_ea", query_ea, 0);
        chk("rst db_ea", db_ea, 0);
        chk("rst lengths", {query_len, db_len}, 0);
        s0 = starts;
        nop(3);
        chk("rst no start pulse", 64'(starts - s0), 0);
        req(1'b0, 3'd1, 64'hABC, 0);
        req(1'b0, 3'd5, 64'h5A5A, 0);
        req(1'b0, 3'd6, 64'hFFFF, 0);
        req(1'b0, 3'd7, 64'hFFFF, 0);
        for (int i = 0; i < 8; i++) req(1'b1, 3'(i), 0, exp8[i]);
        nop(4);
        chk("scoreboard drained", 64'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
